// File: rtl/ai_qtable_arbiter.sv
// rtl/ai_qtable_arbiter.sv - round-robin arbiter sharing one Q-table ROM between two AI players
//
// Purpose: grants one of two players at a time to a single-port, read-only
// Q-table memory, waits out the memory read latency, then returns the
// decoded paddle action (word + 1) and pulses that player's ack.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req0/addr0          player-0 level request and table address
//   req1/addr1          player-1 level request and table address
//   ack0/ack1           one-cycle pulse when action0/action1 is updated
//   action0/action1     last action per player (0 = hold, table actions 1..4)
//   mem_addr/mem_dout   registered address to / read data from the Q-table
//   busy                high whenever the arbiter is not idle
//
// Optional: AI_PERF_CNT_EN adds saturating counters grant_cnt0, grant_cnt1
// and conflict_cnt.
module ai_qtable_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 2,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   output logic              ack0,
   output logic              ack1,
   output logic [2:0]        action0,
   output logic [2:0]        action1,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_dout,
`ifdef AI_PERF_CNT_EN
   output logic [15:0]       grant_cnt0,
   output logic [15:0]       grant_cnt1,
   output logic [15:0]       conflict_cnt,
`endif
   output logic              busy
);

   // Three bits cover the full 1..7 latency range.
   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              gnt_q, gnt_d;
   logic              rr_q, rr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [2:0]        action0_q, action0_d;
   logic [2:0]        action1_q, action1_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic              busy_q, busy_d;
   logic              gnt_sel;
   logic [2:0]        action_new;

   // Table words are 0..3; widening before the +1 keeps 3 -> 4 from wrapping.
   assign action_new = 3'({1'b0, mem_dout}) + 3'd1;

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      rr_d       = rr_q;
      cnt_d      = cnt_q;
      mem_addr_d = mem_addr_q;
      action0_d  = action0_q;
      action1_d  = action1_q;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
      // Contention goes to rr_q; a lone request wins outright.
      gnt_sel    = (req0 && req1) ? rr_q : req1;

      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               gnt_d      = gnt_sel;
               mem_addr_d = gnt_sel ? addr1 : addr0;
               cnt_d      = CNT_W'(MEM_LAT);
               rr_d       = ~gnt_sel;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               if (gnt_q) begin
                  action1_d = action_new;
                  ack1_d    = 1'b1;
               end else begin
                  action0_d = action_new;
                  ack0_d    = 1'b1;
               end
               state_d = S_ACK;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         gnt_q      <= 1'b0;
         rr_q       <= 1'b0;
         cnt_q      <= '0;
         mem_addr_q <= '0;
         action0_q  <= 3'd0;
         action1_q  <= 3'd0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         rr_q       <= rr_d;
         cnt_q      <= cnt_d;
         mem_addr_q <= mem_addr_d;
         action0_q  <= action0_d;
         action1_q  <= action1_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
         busy_q     <= busy_d;
      end
   end

   assign ack0     = ack0_q;
   assign ack1     = ack1_q;
   assign action0  = action0_q;
   assign action1  = action1_q;
   assign mem_addr = mem_addr_q;
   assign busy     = busy_q;

`ifdef AI_PERF_CNT_EN
   logic [15:0] grant_cnt0_q, grant_cnt0_d;
   logic [15:0] grant_cnt1_q, grant_cnt1_d;
   logic [15:0] conflict_cnt_q, conflict_cnt_d;

   always_comb begin
      grant_cnt0_d   = grant_cnt0_q;
      grant_cnt1_d   = grant_cnt1_q;
      conflict_cnt_d = conflict_cnt_q;
      if (state_q == S_ACK && !gnt_q && grant_cnt0_q != 16'hFFFF) begin
         grant_cnt0_d = grant_cnt0_q + 16'd1;
      end
      if (state_q == S_ACK && gnt_q && grant_cnt1_q != 16'hFFFF) begin
         grant_cnt1_d = grant_cnt1_q + 16'd1;
      end
      if (state_q == S_IDLE && req0 && req1 && conflict_cnt_q != 16'hFFFF) begin
         conflict_cnt_d = conflict_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt0_q   <= 16'd0;
         grant_cnt1_q   <= 16'd0;
         conflict_cnt_q <= 16'd0;
      end else begin
         grant_cnt0_q   <= grant_cnt0_d;
         grant_cnt1_q   <= grant_cnt1_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   assign grant_cnt0   = grant_cnt0_q;
   assign grant_cnt1   = grant_cnt1_q;
   assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
